// File: rtl/ysyx_24080006_lsu_if.sv
// rtl/ysyx_24080006_lsu_if.sv - single-outstanding req/rsp data bus between the LSU and memory
interface ysyx_24080006_lsu_if #(
  parameter int XLEN = 32
);
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic            mem_req_we;
  logic [XLEN-1:0] mem_req_addr;
  logic [XLEN-1:0] mem_req_wdata;
  logic [3:0]      mem_req_wstrb;
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rsp_rdata;
  logic            mem_rsp_err;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
  );

  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
  );
endinterface

// File: rtl/ysyx_24080006_lsu.sv
// rtl/ysyx_24080006_lsu.sv - memory-access stage: lane alignment, strobes, load extension, WBU handoff
// Optional misaligned-access fault: define YSYX_24080006_LSU_MISALIGN_CHECK_EN.
module ysyx_24080006_lsu #(
  parameter int XLEN = 32
) (
  input  logic                clock,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     in_pc,
  input  logic [XLEN-1:0]     in_inst,
  input  logic [XLEN-1:0]     in_dnpc,
  input  logic [XLEN-1:0]     in_alu_res,
  input  logic [XLEN-1:0]     in_sdata,
  input  logic [4:0]          in_rd_addr,
  input  logic [2:0]          in_funct3,
  input  logic                in_load,
  input  logic                in_store,
  input  logic                in_wb,
  ysyx_24080006_lsu_if.master mem,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_pc,
  output logic [XLEN-1:0]     out_inst,
  output logic [XLEN-1:0]     out_dnpc,
  output logic [4:0]          out_rd_addr,
  output logic [XLEN-1:0]     out_rd_data,
  output logic                out_wb,
  output logic                out_err
);
  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] addr_q, sdata_q;
  logic [2:0]      funct3_q;
  logic            load_q, store_q, wb_q, err_q;
  logic            accept, mem_op, misalign;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] load_data;

  assign accept = in_valid && (state_q == IDLE);
  assign mem_op = in_load || in_store;

`ifdef YSYX_24080006_LSU_MISALIGN_CHECK_EN
  always_comb begin
    case (in_funct3[1:0])
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = in_alu_res[0];
      default: misalign = |in_alu_res[1:0];
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d           = state_q;
    in_ready          = 1'b0;
    out_valid         = 1'b0;
    mem.mem_req_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = (mem_op && !misalign) ? REQ : DONE;
      end
      REQ: begin
        mem.mem_req_valid = 1'b1;
        if (mem.mem_req_ready) state_d = RSP;
      end
      RSP: begin
        if (mem.mem_rsp_valid) state_d = DONE;
      end
      default: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
    endcase
  end

  // funct3[1:0]: 00 byte, 01 half, anything else is treated as a full word.
  always_comb begin
    case (addr_q[1:0])
      2'b00:   byte_sel = mem.mem_rsp_rdata[7:0];
      2'b01:   byte_sel = mem.mem_rsp_rdata[15:8];
      2'b10:   byte_sel = mem.mem_rsp_rdata[23:16];
      default: byte_sel = mem.mem_rsp_rdata[31:24];
    endcase
    half_sel = addr_q[1] ? mem.mem_rsp_rdata[31:16] : mem.mem_rsp_rdata[15:0];
    case (funct3_q)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_data = {24'd0, byte_sel};
      3'b101:  load_data = {16'd0, half_sel};
      default: load_data = mem.mem_rsp_rdata;
    endcase
  end

  always_comb begin
    mem.mem_req_we   = store_q;
    mem.mem_req_addr = {addr_q[XLEN-1:2], 2'b00};
    case (funct3_q[1:0])
      2'b00: begin
        mem.mem_req_wdata = {4{sdata_q[7:0]}};
        mem.mem_req_wstrb = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        mem.mem_req_wdata = {2{sdata_q[15:0]}};
        mem.mem_req_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        mem.mem_req_wdata = sdata_q;
        mem.mem_req_wstrb = 4'b1111;
      end
    endcase
    if (!store_q) mem.mem_req_wstrb = 4'b0000;
  end

  assign out_err = err_q;
  assign out_wb  = wb_q && !store_q && !err_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      out_pc      <= '0;
      out_inst    <= '0;
      out_dnpc    <= '0;
      out_rd_addr <= '0;
      out_rd_data <= '0;
      addr_q      <= '0;
      sdata_q     <= '0;
      funct3_q    <= '0;
      load_q      <= 1'b0;
      store_q     <= 1'b0;
      wb_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (accept) begin
        out_pc      <= in_pc;
        out_inst    <= in_inst;
        out_dnpc    <= in_dnpc;
        out_rd_addr <= in_rd_addr;
        out_rd_data <= mem_op ? '0 : in_alu_res;
        addr_q      <= in_alu_res;
        sdata_q     <= in_sdata;
        funct3_q    <= in_funct3;
        load_q      <= in_load;
        store_q     <= in_store;
        wb_q        <= in_wb;
        err_q       <= mem_op && misalign;
      end
      // A faulted access writes back nothing, so its data is cleared too.
      if (state_q == RSP && mem.mem_rsp_valid) begin
        err_q       <= mem.mem_rsp_err;
        out_rd_data <= (load_q && !mem.mem_rsp_err) ? load_data : '0;
      end
    end
  end
endmodule

// File: tb/tb_ysyx_24080006_lsu.sv
// tb/tb_ysyx_24080006_lsu.sv - randomized bench for ysyx_24080006_lsu against a transaction-level model
module tb_ysyx_24080006_lsu;
  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0, in_inst = '0, in_dnpc = '0, in_alu_res = '0, in_sdata = '0;
  logic [4:0]  in_rd_addr = '0;
  logic [2:0]  in_funct3 = '0;
  logic        in_load = 1'b0, in_store = 1'b0, in_wb = 1'b0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc, out_inst, out_dnpc, out_rd_data;
  logic [4:0]  out_rd_addr;
  logic        out_wb, out_err;

  ysyx_24080006_lsu_if bus ();

  ysyx_24080006_lsu dut (
    .clock(clock), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .in_dnpc(in_dnpc),
    .in_alu_res(in_alu_res), .in_sdata(in_sdata), .in_rd_addr(in_rd_addr),
    .in_funct3(in_funct3), .in_load(in_load), .in_store(in_store), .in_wb(in_wb),
    .mem(bus),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_dnpc(out_dnpc),
    .out_rd_addr(out_rd_addr), .out_rd_data(out_rd_data),
    .out_wb(out_wb), .out_err(out_err)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s timed out", name);
  endtask

  bit          rand_mode = 0, stray_en = 0, force_err = 0, inject_stray = 0;
  bit          dir_req_ready = 1, dir_out_ready = 1;
  logic [31:0] dir_rdata = '0;

  // Ready inputs change only just after a rising edge.
  initial begin
    bus.mem_req_ready = 1'b0;
    out_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (rand_mode) begin
        bus.mem_req_ready = ($urandom % 3) != 0;
        out_ready = ($urandom % 3) != 0;
      end else begin
        bus.mem_req_ready = dir_req_ready;
        out_ready = dir_out_ready;
      end
    end
  end

  // Memory: one response per accepted request after 0..3 idle cycles, plus stray pulses while idle.
  initial begin
    bit pend, nv, nerr;
    int dly;
    logic [31:0] ndata;
    pend = 0; dly = 0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_rdata = '0;
    bus.mem_rsp_err = 1'b0;
    forever begin
      @(negedge clock);
      nv = 0; nerr = 0; ndata = $urandom;
      if (!rst_n) begin
        pend = 0;
      end else begin
        if (pend) begin
          if (dly == 0) begin
            nv = 1; pend = 0;
            ndata = rand_mode ? $urandom : dir_rdata;
            nerr = rand_mode ? (($urandom % 8) == 0) : force_err;
          end else dly--;
        end else if (!bus.mem_req_valid && (inject_stray || (stray_en && ($urandom % 6) == 0))) begin
          nv = 1; nerr = $urandom % 2; inject_stray = 0;
        end
        if (bus.mem_req_valid && bus.mem_req_ready) begin
          pend = 1;
          dly = $urandom_range(0, 3);
        end
      end
      @(posedge clock);
      #1;
      bus.mem_rsp_valid = nv;
      bus.mem_rsp_rdata = ndata;
      bus.mem_rsp_err = nerr;
    end
  end

  function automatic int acc_size(input logic [2:0] f3);
    if (f3 % 4 == 0) return 1;
    if (f3 % 4 == 1) return 2;
    return 4;
  endfunction

  function automatic bit is_misaligned(input bit memop, input logic [31:0] a, input logic [2:0] f3);
`ifdef YSYX_24080006_LSU_MISALIGN_CHECK_EN
    int sz;
    sz = acc_size(f3);
    return memop && ((sz == 2 && a % 2 != 0) || (sz == 4 && a % 4 != 0));
`else
    return 0;
`endif
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] rd, input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] v;
    bit sgn;
    sgn = f3 < 4;
    case (acc_size(f3))
      1: begin
        v = (rd >> (8 * (a % 4))) & 32'hFF;
        if (sgn && v >= 128) v = v | 32'hFFFF_FF00;
      end
      2: begin
        v = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        if (sgn && v >= 32768) v = v | 32'hFFFF_0000;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] store_wdata(input logic [31:0] sd, input logic [2:0] f3);
    case (acc_size(f3))
      1: return (sd & 32'hFF) * 32'h0101_0101;
      2: return (sd & 32'hFFFF) * 32'h0001_0001;
      default: return sd;
    endcase
  endfunction

  function automatic logic [3:0] store_wstrb(input logic [31:0] a, input logic [2:0] f3);
    case (acc_size(f3))
      1: return 4'(1 << (a % 4));
      2: return 4'(3 << (a & 2));
      default: return 4'hF;
    endcase
  endfunction

  // Transaction model: one instruction in flight, tracked by what has happened to it so far.
  bit          m_busy = 0, m_mem, m_load, m_store, m_wb, m_mis, m_err, m_req_done, m_rsp_seen;
  int          m_age;
  logic [31:0] m_pc, m_inst, m_dnpc, m_alu, m_sdata, m_rdata;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;

  initial begin
    bit avail, exp_req;
    logic [31:0] exp_data;
    forever begin
      @(negedge clock);
      if (!rst_n) begin
        m_busy = 0;
      end else begin
        if (m_busy) m_age++;
        avail = m_busy && ((m_mem && !m_mis) ? m_rsp_seen : (m_age >= 1));
        exp_req = m_busy && m_mem && !m_mis && !m_req_done && m_age >= 1;
        chk("in_ready", in_ready, !m_busy);
        chk("mem_req_valid", bus.mem_req_valid, exp_req);
        if (exp_req && bus.mem_req_valid) begin
          chk("mem_req_addr", bus.mem_req_addr, m_alu & 32'hFFFF_FFFC);
          chk("mem_req_we", bus.mem_req_we, m_store);
          chk("mem_req_wstrb", bus.mem_req_wstrb, m_store ? store_wstrb(m_alu, m_f3) : 4'h0);
          if (m_store) chk("mem_req_wdata", bus.mem_req_wdata, store_wdata(m_sdata, m_f3));
        end
        chk("out_valid", out_valid, avail);
        if (avail && out_valid) begin
          chk("out_pc", out_pc, m_pc);
          chk("out_inst", out_inst, m_inst);
          chk("out_dnpc", out_dnpc, m_dnpc);
          chk("out_rd_addr", out_rd_addr, m_rd);
          chk("out_err", out_err, m_err);
          chk("out_wb", out_wb, m_wb && !m_store && !m_err);
          if (m_mis) exp_data = 0;
          else if (!m_mem) exp_data = m_alu;
          else if (m_store) exp_data = 0;
          else exp_data = load_val(m_rdata, m_alu, m_f3);
          if (!m_err || m_mis) chk("out_rd_data", out_rd_data, exp_data);
        end
        if (m_busy && m_mem && !m_mis && m_req_done && !m_rsp_seen && bus.mem_rsp_valid) begin
          m_rsp_seen = 1;
          m_rdata = bus.mem_rsp_rdata;
          m_err = bus.mem_rsp_err;
        end
        if (exp_req && bus.mem_req_valid && bus.mem_req_ready) m_req_done = 1;
        if (avail && out_valid && out_ready) m_busy = 0;
        if (in_valid && in_ready && !m_busy) begin
          m_busy = 1; m_age = 0; m_req_done = 0; m_rsp_seen = 0;
          m_pc = in_pc; m_inst = in_inst; m_dnpc = in_dnpc; m_alu = in_alu_res;
          m_sdata = in_sdata; m_rd = in_rd_addr; m_f3 = in_funct3;
          m_load = in_load; m_store = in_store; m_wb = in_wb;
          m_mem = in_load || in_store;
          m_mis = is_misaligned(m_mem, in_alu_res, in_funct3);
          m_err = m_mis;
        end
      end
    end
  end

  bit          saw_req;
  int          lat;
  logic [31:0] r_addr, r_wdata, o_rd_data;
  logic [3:0]  r_wstrb;
  logic        o_err, o_wb;

  task automatic issue(input logic [31:0] alu, input logic [31:0] sd, input logic [2:0] f3,
                       input bit ld, input bit st, input bit wb, input logic [4:0] rd);
    bit ok;
    @(posedge clock);
    #1;
    in_alu_res = alu; in_sdata = sd; in_funct3 = f3; in_load = ld; in_store = st;
    in_wb = wb; in_rd_addr = rd; in_pc = $urandom; in_inst = $urandom; in_dnpc = $urandom;
    in_valid = 1;
    ok = 0;
    for (int n = 0; n < 60 && !ok; n++) begin
      @(negedge clock);
      ok = in_ready;
    end
    if (!ok) timeout("accept");
    @(posedge clock);
    #1;
    in_valid = 0;
    in_alu_res = $urandom; in_sdata = $urandom; in_funct3 = 3'($urandom);
  endtask

  task automatic wait_out();
    bit ok;
    ok = 0; lat = 0; saw_req = 0;
    while (!ok && lat < 60) begin
      @(negedge clock);
      lat++;
      if (bus.mem_req_valid) begin
        saw_req = 1; r_addr = bus.mem_req_addr; r_wdata = bus.mem_req_wdata; r_wstrb = bus.mem_req_wstrb;
      end
      ok = out_valid;
    end
    if (!ok) timeout("out_valid");
    o_rd_data = out_rd_data; o_err = out_err; o_wb = out_wb;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clock);
      ok = in_ready && !out_valid;
    end
    if (!ok) timeout("idle");
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_mem_req_valid", bus.mem_req_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_out_wb", out_wb, 0);
    chk("rst_out_rd_data", out_rd_data, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_wstrb", bus.mem_req_wstrb, 0);
    @(posedge clock);
    #1 rst_n = 1;

    issue(32'h1234_5678, 0, 3'b000, 0, 0, 1, 5'd5);
    wait_out();
    chk("alu_latency", lat, 1);
    chk("alu_data", o_rd_data, 32'h1234_5678);
    chk("alu_no_req", saw_req, 0);
    chk("alu_wb", o_wb, 1);
    wait_idle();

    dir_rdata = 32'h80FF_0000;
    issue(32'h8000_0003, 0, 3'b000, 1, 0, 1, 5'd7);
    wait_out();
    chk("lb_addr", r_addr, 32'h8000_0000);
    chk("lb_wstrb", r_wstrb, 4'b0000);
    chk("lb_data", o_rd_data, 32'hFFFF_FF80);
    wait_idle();
    issue(32'h8000_0003, 0, 3'b100, 1, 0, 1, 5'd7);
    wait_out();
    chk("lbu_data", o_rd_data, 32'h0000_0080);
    wait_idle();

    issue(32'h8000_0002, 32'hAAAA_BEEF, 3'b001, 0, 1, 1, 5'd3);
    wait_out();
    chk("sh_wdata", r_wdata, 32'hBEEF_BEEF);
    chk("sh_wstrb", r_wstrb, 4'b1100);
    chk("sh_wb", o_wb, 0);
    wait_idle();

    dir_req_ready = 0; dir_out_ready = 0; dir_rdata = 32'hDEAD_BEEF;
    fork
      issue(32'h8000_0010, 0, 3'b010, 1, 0, 1, 5'd9);
      begin repeat (5) @(negedge clock); dir_req_ready = 1; end
    join
    wait_out();
    chk("bp_lw_data", o_rd_data, 32'hDEAD_BEEF);
    repeat (2) @(negedge clock);
    chk("bp_hold_valid", out_valid, 1);
    chk("bp_hold_ready", in_ready, 0);
    dir_out_ready = 1;
    wait_idle();

    force_err = 1;
    issue(32'h8000_0004, 0, 3'b010, 1, 0, 1, 5'd4);
    wait_out();
    chk("err_flag", o_err, 1);
    chk("err_wb", o_wb, 0);
    wait_idle();
    force_err = 0;
    issue(32'h0000_0042, 0, 3'b000, 0, 0, 1, 5'd4);
    wait_out();
    chk("after_err_flag", o_err, 0);
    chk("after_err_data", o_rd_data, 32'h0000_0042);
    wait_idle();

    dir_rdata = 32'hCAFE_F00D;
    issue(32'h8000_0002, 0, 3'b010, 1, 0, 1, 5'd6);
    wait_out();
`ifdef YSYX_24080006_LSU_MISALIGN_CHECK_EN
    chk("mis_no_req", saw_req, 0);
    chk("mis_latency", lat, 1);
    chk("mis_err", o_err, 1);
    chk("mis_data", o_rd_data, 0);
`else
    chk("lw_low_bits_ignored", o_rd_data, 32'hCAFE_F00D);
    chk("lw_unaligned_err", o_err, 0);
`endif
    wait_idle();

    dir_req_ready = 0;
    issue(32'h8000_0020, 0, 3'b010, 1, 0, 1, 5'd8);
    begin
      bit ok;
      ok = 0;
      for (int n = 0; n < 10 && !ok; n++) begin
        @(negedge clock);
        ok = bus.mem_req_valid;
      end
      if (!ok) timeout("req_before_reset");
    end
    #1 rst_n = 0;
    #1;
    chk("rst_mid_req_drop", bus.mem_req_valid, 0);
    @(negedge clock);
    @(posedge clock);
    #1 rst_n = 1;
    dir_req_ready = 1;
    @(negedge clock);
    #1;
    chk("rst_mid_in_ready", in_ready, 1);
    inject_stray = 1;
    repeat (3) @(negedge clock);
    chk("stray_ignored", out_valid, 0);
    issue(32'h0000_0077, 0, 3'b000, 0, 0, 1, 5'd2);
    wait_out();
    chk("post_rst_data", o_rd_data, 32'h0000_0077);
    wait_idle();

    rand_mode = 1;
    stray_en = 1;
    for (int i = 0; i < 400; i++) begin
      int cls;
      logic [31:0] a;
      cls = $urandom % 3;
      a = $urandom;
      if (cls != 0 && ($urandom % 2)) a = 32'h8000_0000 | (a & 32'hFF);
      issue(a, $urandom, 3'($urandom), cls == 1, cls == 2, $urandom % 2, 5'($urandom));
      repeat ($urandom % 3) @(posedge clock);
    end
    rand_mode = 0;
    stray_en = 0;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
